// File: rtl/eth_port_rx_buf.sv
// Store-and-forward ingress buffer for one switch port; only complete packets are released.
// Build option ETH_RX_STATS_EN adds saturating rxPktCount/rxDropCount outputs.
//
// state | meaning
// IDLE  | between packets, waiting for SOP
// RECV  | writing words of an accepted packet
// DROP  | discarding the remainder of an aborted packet
module eth_port_rx_buf #(
  parameter int DEPTH         = 64,
  parameter int MAX_PKT_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inData,
  input  logic        inSop,
  input  logic        inEop,
  output logic        portStall,
  output logic [31:0] outData,
  output logic        outSop,
  output logic        outEop,
  output logic        outValid,
  input  logic        outReady
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0] rxPktCount,
  output logic [15:0] rxDropCount
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t state, stateNext;

  logic [PW-1:0] wrPtr, wrPtrNext, pktStart, pktStartNext;
  logic [PW-1:0] commitPtr, commitPtrNext, rdPtr;
  logic [PW-1:0] wrAddr, sopBase, occupancy, freeWords;
  logic [CW-1:0] cnt, cntNext;
  logic [33:0]   mem [DEPTH];
  logic [33:0]   headWord;
  logic          wrEn, pop, fifoFull, sopFull, cntLimit;

  assign occupancy = wrPtr - rdPtr;
  assign freeWords = PW'(DEPTH) - occupancy;
  assign fifoFull  = (occupancy == PW'(DEPTH));
  assign cntLimit  = (cnt == CW'(MAX_PKT_WORDS));
  // A SOP in RECV abandons the open packet, so it restarts from pktStart.
  assign sopBase   = (state == RECV) ? pktStart : wrPtr;
  assign sopFull   = ((sopBase - rdPtr) == PW'(DEPTH));

  always_comb begin
    stateNext     = state;
    wrPtrNext     = wrPtr;
    pktStartNext  = pktStart;
    commitPtrNext = commitPtr;
    cntNext       = cnt;
    wrEn          = 1'b0;
    wrAddr        = wrPtr;
    if (inSop) begin
      if (sopFull) begin
        wrPtrNext = sopBase;
        stateNext = inEop ? IDLE : DROP;
      end else begin
        wrEn         = 1'b1;
        wrAddr       = sopBase;
        pktStartNext = sopBase;
        wrPtrNext    = sopBase + 1'b1;
        cntNext      = CW'(1);
        if (inEop) begin
          commitPtrNext = sopBase + 1'b1;
          stateNext     = IDLE;
        end else begin
          stateNext = RECV;
        end
      end
    end else if (state == RECV) begin
      if (cntLimit || fifoFull) begin
        wrPtrNext = pktStart;
        stateNext = inEop ? IDLE : DROP;
      end else begin
        wrEn      = 1'b1;
        wrPtrNext = wrPtr + 1'b1;
        cntNext   = cnt + 1'b1;
        if (inEop) begin
          commitPtrNext = wrPtr + 1'b1;
          stateNext     = IDLE;
        end
      end
    end else if (state == DROP && inEop) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wrPtr     <= '0;
      pktStart  <= '0;
      commitPtr <= '0;
      rdPtr     <= '0;
      cnt       <= '0;
      portStall <= 1'b0;
    end else begin
      state     <= stateNext;
      wrPtr     <= wrPtrNext;
      pktStart  <= pktStartNext;
      commitPtr <= commitPtrNext;
      cnt       <= cntNext;
      if (pop) rdPtr <= rdPtr + 1'b1;
      // One word of margin absorbs the registration lag seen by the sender.
      portStall <= freeWords < PW'(MAX_PKT_WORDS + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr[AW-1:0]] <= {inSop, inEop, inData};
  end

  assign headWord = mem[rdPtr[AW-1:0]];
  assign outValid = (commitPtr != rdPtr);
  assign outData  = outValid ? headWord[31:0] : 32'h0;
  assign outSop   = outValid & headWord[33];
  assign outEop   = outValid & headWord[32];
  assign pop      = outValid & outReady;

`ifdef ETH_RX_STATS_EN
  logic pktDone, pktDrop;
  assign pktDone = (commitPtrNext != commitPtr);
  assign pktDrop = ((state == RECV) && (inSop || cntLimit || fifoFull)) || (inSop && sopFull);

  always_ff @(posedge clk) begin
    if (reset) begin
      rxPktCount  <= '0;
      rxDropCount <= '0;
    end else begin
      if (pktDone && rxPktCount != 16'hFFFF) rxPktCount <= rxPktCount + 1'b1;
      if (pktDrop && rxDropCount != 16'hFFFF) rxDropCount <= rxDropCount + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_eth_port_rx_buf.sv
// Directed bench for eth_port_rx_buf: framing, drops, stall/drain and mid-packet reset.
module tb_eth_port_rx_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inData;
  logic        inSop, inEop;
  logic        portStall;
  logic [31:0] outData;
  logic        outSop, outEop, outValid;
  logic        outReady;
`ifdef ETH_RX_STATS_EN
  logic [15:0] rxPktCount, rxDropCount;
`endif

  int assertCount = 0;
  int failCount   = 0;
  logic [33:0] rxQ[$];
  logic [33:0] expQ[$];

  eth_port_rx_buf #(.DEPTH(64), .MAX_PKT_WORDS(16)) dut (
    .clk(clk), .reset(reset), .inData(inData), .inSop(inSop), .inEop(inEop),
    .portStall(portStall), .outData(outData), .outSop(outSop), .outEop(outEop),
    .outValid(outValid), .outReady(outReady)
`ifdef ETH_RX_STATS_EN
    , .rxPktCount(rxPktCount), .rxDropCount(rxDropCount)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (outValid && outReady) rxQ.push_back({outSop, outEop, outData});
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic s, input logic e);
    inData = d; inSop = s; inEop = e;
    tick();
    inData = 32'h0; inSop = 1'b0; inEop = 1'b0;
  endtask

  task automatic sendPkt(input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) sendWord(base + 32'(i), i == 0, i == len - 1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rxQ.delete();
  endtask

  task automatic checkRx(input string tag);
    checkEq({tag, " count"}, 64'(rxQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < rxQ.size()) checkEq($sformatf("%s w%0d", tag, i), 64'(rxQ[i]), 64'(expQ[i]));
    end
  endtask

  initial begin
    int accepted;
    int waited;
    reset = 1'b1; inData = 32'h0; inSop = 1'b0; inEop = 1'b0; outReady = 1'b0;
    tick();
    tick();
    checkEq("rst outValid", outValid, 0);
    checkEq("rst outSop", outSop, 0);
    checkEq("rst outEop", outEop, 0);
    checkEq("rst outData", outData, 0);
    checkEq("rst portStall", portStall, 0);
    reset = 1'b0;
    rxQ.delete();

    // 4-word packet, first-word latency
    outReady = 1'b1;
    sendWord(32'h11, 1, 0);
    sendWord(32'h12, 0, 0);
    sendWord(32'h13, 0, 0);
    checkEq("t1 valid before eop", outValid, 0);
    sendWord(32'h14, 0, 1);
    checkEq("t1 valid after eop", outValid, 1);
    checkEq("t1 head sop", outSop, 1);
    checkEq("t1 head data", outData, 32'h11);
    repeat (6) tick();
    expQ.delete();
    expQ.push_back({2'b10, 32'h11});
    expQ.push_back({2'b00, 32'h12});
    expQ.push_back({2'b00, 32'h13});
    expQ.push_back({2'b01, 32'h14});
    checkRx("t1");

    // one-word packet
    doReset();
    sendWord(32'hDEADBEEF, 1, 1);
    checkEq("t2 valid", outValid, 1);
    repeat (3) tick();
    expQ.delete();
    expQ.push_back({2'b11, 32'hDEADBEEF});
    checkRx("t2");
`ifdef ETH_RX_STATS_EN
    checkEq("t2 pktCount", rxPktCount, 1);
    checkEq("t2 dropCount", rxDropCount, 0);
`endif

    // oversize packet dropped, next packet kept
    doReset();
    sendPkt(32'h300, 17);
    sendPkt(32'h400, 2);
    repeat (5) tick();
    expQ.delete();
    expQ.push_back({2'b10, 32'h400});
    expQ.push_back({2'b01, 32'h401});
    checkRx("t3");
`ifdef ETH_RX_STATS_EN
    checkEq("t3 pktCount", rxPktCount, 1);
    checkEq("t3 dropCount", rxDropCount, 1);
`endif

    // missing EOP: new SOP abandons the open packet
    doReset();
    sendWord(32'h500, 1, 0);
    sendWord(32'h501, 0, 0);
    sendWord(32'h502, 0, 0);
    sendPkt(32'h600, 2);
    repeat (5) tick();
    expQ.delete();
    expQ.push_back({2'b10, 32'h600});
    expQ.push_back({2'b01, 32'h601});
    checkRx("t4");
`ifdef ETH_RX_STATS_EN
    checkEq("t4 pktCount", rxPktCount, 1);
    checkEq("t4 dropCount", rxDropCount, 1);
`endif

    // stall with outReady=0, then drain
    outReady = 1'b0;
    doReset();
    accepted = 0;
    for (int p = 0; p < 5; p++) begin
      waited = 0;
      while (portStall && waited < 20) begin
        tick();
        waited++;
      end
      if (!portStall) begin
        sendPkt(32'h1000 * 32'(p + 1), 16);
        accepted++;
      end
    end
    checkEq("t5 accepted pkts", 64'(accepted), 4);
    checkEq("t5 stall high", portStall, 1);
    checkEq("t5 hold valid", outValid, 1);
    checkEq("t5 hold data", outData, 32'h1000);
    tick();
    checkEq("t5 hold data2", outData, 32'h1000);
    checkEq("t5 hold sop", outSop, 1);
    outReady = 1'b1;
    repeat (70) tick();
    expQ.delete();
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 16; i++)
        expQ.push_back({i == 0, i == 15, 32'h1000 * 32'(p + 1) + 32'(i)});
    checkRx("t5");
    checkEq("t5 stall released", portStall, 0);
    checkEq("t5 drained", outValid, 0);

    // reset mid-packet with committed data present
    outReady = 1'b0;
    doReset();
    sendPkt(32'h700, 2);
    sendPkt(32'h800, 2);
    sendWord(32'h900, 1, 0);
    sendWord(32'h901, 0, 0);
    checkEq("t6 valid pre-reset", outValid, 1);
    reset = 1'b1;
    tick();
    checkEq("t6 valid after reset", outValid, 0);
    reset = 1'b0;
    rxQ.delete();
    outReady = 1'b1;
    sendPkt(32'hA00, 3);
    repeat (5) tick();
    expQ.delete();
    expQ.push_back({2'b10, 32'hA00});
    expQ.push_back({2'b00, 32'hA01});
    expQ.push_back({2'b01, 32'hA02});
    checkRx("t6");
`ifdef ETH_RX_STATS_EN
    checkEq("t6 pktCount", rxPktCount, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
